// File: rtl/dnpcie_aurora_rx_path_adapter.sv
// dnpcie_aurora_rx_path_adapter: 32-bit Aurora RX stream to 16-bit AXI4-Stream with CRC-16 check and strip.
// Optional err_count saturating error counter enabled by DNPCIE_AURORA_RX_ERRCNT_EN.
module dnpcie_aurora_rx_path_adapter (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        channel_up,
    input  logic [0:31] s_axis_tdata,
    input  logic [0:3]  s_axis_tkeep,
    input  logic        s_axis_tlast,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    output logic [0:15] m_axis_tdata,
    output logic [0:1]  m_axis_tkeep,
    output logic        m_axis_tlast,
    output logic        m_axis_tuser,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        crc_error
`ifdef DNPCIE_AURORA_RX_ERRCNT_EN
    ,output logic [15:0] err_count
`endif
);
    function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic [15:0] d);
        logic [15:0] r;
        r = c;
        for (int i = 15; i >= 0; i--) r = {r[14:0], 1'b0} ^ ((r[15] ^ d[i]) ? 16'h1021 : 16'h0000);
        return r;
    endfunction

    logic        ib_v_q, ib_v_d, ib_last_q, ib_last_d, ph_q, ph_d;
    logic [0:31] ib_data_q, ib_data_d;
    logic [0:3]  ib_keep_q, ib_keep_d;
    logic        hv_q, hv_d, bad_q, bad_d, drop_q, drop_d, up_q;
    logic [15:0] hd_q, hd_d, crc_q, crc_d, od_q, od_d;
    logic        ov_q, ov_d, olast_q, olast_d, ouser_q, ouser_d, err_q, err_d;
    logic        adv, live, keep_bad, final_hw, hw_last, take, consume;
    logic [15:0] hw, crc_nx;

    assign adv      = !ov_q || m_axis_tready;
    assign live     = channel_up && up_q && !drop_q;
    assign keep_bad = ib_keep_q[0:1] != 2'b11;
    assign final_hw = ph_q || ib_keep_q[2:3] != 2'b11;
    assign hw       = ph_q ? ib_data_q[16:31] : ib_data_q[0:15];
    assign hw_last  = ib_last_q && final_hw;
    assign crc_nx   = crc16_step(crc_q, hw);
    assign take     = live && ib_v_q && adv;
    assign consume  = take && (keep_bad || final_hw);

    assign s_axis_tready = live && (!ib_v_q || consume);
    assign m_axis_tdata  = od_q;
    assign m_axis_tkeep  = 2'b11;
    assign m_axis_tlast  = olast_q;
    assign m_axis_tuser  = ouser_q;
    assign m_axis_tvalid = ov_q;
    assign crc_error     = err_q;

    always_comb begin
        ib_v_d    = ib_v_q;
        ib_data_d = ib_data_q;
        ib_keep_d = ib_keep_q;
        ib_last_d = ib_last_q;
        ph_d      = ph_q;
        hv_d      = hv_q;
        hd_d      = hd_q;
        bad_d     = bad_q;
        crc_d     = crc_q;
        drop_d    = drop_q;
        ov_d      = ov_q && !m_axis_tready;
        od_d      = od_q;
        olast_d   = olast_q;
        ouser_d   = ouser_q;
        err_d     = 1'b0;
        // A held halfword is flushed as an errored last beat; drop_q keeps it pending under backpressure
        if (!channel_up || drop_q) begin
            ib_v_d = 1'b0;
            ph_d   = 1'b0;
            hv_d   = 1'b0;
            bad_d  = 1'b0;
            crc_d  = 16'hFFFF;
            drop_d = (hv_q || drop_q) && !adv;
            if ((hv_q || drop_q) && adv) begin
                ov_d    = 1'b1;
                od_d    = hd_q;
                olast_d = 1'b1;
                ouser_d = 1'b1;
                err_d   = 1'b1;
            end
        end else if (take) begin
            if (keep_bad) begin
                ib_v_d = 1'b0;
                ph_d   = 1'b0;
                bad_d  = 1'b1;
                if (ib_last_q) begin
                    hv_d  = 1'b0;
                    bad_d = 1'b0;
                    crc_d = 16'hFFFF;
                    err_d = 1'b1;
                    if (hv_q) begin
                        ov_d    = 1'b1;
                        od_d    = hd_q;
                        olast_d = 1'b1;
                        ouser_d = 1'b1;
                    end
                end
            end else begin
                ib_v_d = !final_hw;
                ph_d   = !final_hw;
                if (hv_q) begin
                    ov_d    = 1'b1;
                    od_d    = hd_q;
                    olast_d = hw_last;
                    ouser_d = hw_last && (bad_q || crc_nx != 16'h0000);
                end
                if (hw_last) begin
                    hv_d  = 1'b0;
                    bad_d = 1'b0;
                    crc_d = 16'hFFFF;
                    err_d = !hv_q || bad_q || crc_nx != 16'h0000;
                end else begin
                    hv_d  = 1'b1;
                    hd_d  = hw;
                    crc_d = crc_nx;
                end
            end
        end
        if (s_axis_tready && s_axis_tvalid) begin
            ib_v_d    = 1'b1;
            ib_data_d = s_axis_tdata;
            ib_keep_d = s_axis_tkeep;
            ib_last_d = s_axis_tlast;
            ph_d      = 1'b0;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            ib_v_q    <= 1'b0;
            ib_data_q <= '0;
            ib_keep_q <= '0;
            ib_last_q <= 1'b0;
            ph_q      <= 1'b0;
            hv_q      <= 1'b0;
            hd_q      <= '0;
            bad_q     <= 1'b0;
            crc_q     <= 16'hFFFF;
            drop_q    <= 1'b0;
            up_q      <= 1'b0;
            ov_q      <= 1'b0;
            od_q      <= '0;
            olast_q   <= 1'b0;
            ouser_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            ib_v_q    <= ib_v_d;
            ib_data_q <= ib_data_d;
            ib_keep_q <= ib_keep_d;
            ib_last_q <= ib_last_d;
            ph_q      <= ph_d;
            hv_q      <= hv_d;
            hd_q      <= hd_d;
            bad_q     <= bad_d;
            crc_q     <= crc_d;
            drop_q    <= drop_d;
            up_q      <= channel_up;
            ov_q      <= ov_d;
            od_q      <= od_d;
            olast_q   <= olast_d;
            ouser_q   <= ouser_d;
            err_q     <= err_d;
        end
    end

`ifdef DNPCIE_AURORA_RX_ERRCNT_EN
    logic [15:0] err_cnt_q;
    assign err_count = err_cnt_q;
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) err_cnt_q <= '0;
        else if (err_d && err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
    end
`endif
endmodule

// File: tb/tb_dnpcie_aurora_rx_path_adapter.sv
// tb_dnpcie_aurora_rx_path_adapter: randomized frames against a frame-level reference queue.
module tb_dnpcie_aurora_rx_path_adapter;
    logic        aclk = 1'b0, aresetn = 1'b0, channel_up = 1'b0;
    logic [0:31] s_axis_tdata = '0;
    logic [0:3]  s_axis_tkeep = '0;
    logic        s_axis_tlast = 1'b0, s_axis_tvalid = 1'b0, s_axis_tready;
    logic [0:15] m_axis_tdata;
    logic [0:1]  m_axis_tkeep;
    logic        m_axis_tlast, m_axis_tuser, m_axis_tvalid, m_axis_tready = 1'b1, crc_error;
`ifdef DNPCIE_AURORA_RX_ERRCNT_EN
    logic [15:0] err_count;
`endif

    dnpcie_aurora_rx_path_adapter dut (
        .aclk(aclk), .aresetn(aresetn), .channel_up(channel_up),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tlast(s_axis_tlast),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast),
        .m_axis_tuser(m_axis_tuser), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .crc_error(crc_error)
`ifdef DNPCIE_AURORA_RX_ERRCNT_EN
        , .err_count(err_count)
`endif
    );

    always #5 aclk = ~aclk;

    int errors = 0, checks = 0;
    int exp_errs = 0, seen_errs = 0, gap_pct = 0, rmode = 0;
    logic [17:0] exp_q[$];
    logic        prev_stall = 1'b0;
    logic [17:0] prev_out;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] crc_ccitt(input logic [15:0] p[$]);
        logic [15:0] c = 16'hFFFF;
        foreach (p[j])
            for (int b = 15; b >= 0; b--)
                c = (c[15] ^ p[j][b]) ? ((c << 1) ^ 16'h1021) : (c << 1);
        return c;
    endfunction

    always @(posedge aclk) begin
        #1;
        case (rmode)
            0: m_axis_tready = 1'b1;
            1: m_axis_tready = $urandom_range(99) < 70;
            2: m_axis_tready = ~m_axis_tready;
            default: m_axis_tready = 1'b0;
        endcase
    end

    always @(negedge aclk) if (aresetn) begin
        logic [17:0] e;
        if (crc_error) seen_errs++;
        if (prev_stall) check("hold", {m_axis_tuser, m_axis_tlast, m_axis_tdata}, prev_out);
        if (m_axis_tvalid && m_axis_tready) begin
            if (exp_q.size() == 0) check("unexpected_out", {m_axis_tlast, m_axis_tdata}, 32'hFFFFFFFF);
            else begin
                e = exp_q.pop_front();
                check("tdata", m_axis_tdata, e[15:0]);
                check("tlast", m_axis_tlast, e[16]);
                check("tkeep", m_axis_tkeep, 2'b11);
                if (e[16]) check("tuser", m_axis_tuser, e[17]);
            end
        end
        prev_stall = m_axis_tvalid && !m_axis_tready;
        prev_out   = {m_axis_tuser, m_axis_tlast, m_axis_tdata};
    end

    task automatic send_beat(input logic [0:31] d, input logic [0:3] k, input logic l);
        int t = 0;
        s_axis_tdata  = d;
        s_axis_tkeep  = k;
        s_axis_tlast  = l;
        s_axis_tvalid = 1'b1;
        do begin
            @(negedge aclk);
            t++;
        end while (!s_axis_tready && t < 3000);
        if (!s_axis_tready) check("s_ready_timeout", 0, 1);
        @(posedge aclk);
        #1 s_axis_tvalid = 1'b0;
    endtask

    task automatic send_payload(input logic [15:0] p[$], input bit corrupt);
        logic [15:0] h[$];
        logic [15:0] c;
        h = p;
        c = crc_ccitt(p);
        if (corrupt) c = c ^ (16'h1 << $urandom_range(15, 0));
        h.push_back(c);
        foreach (p[j]) exp_q.push_back({corrupt, j == p.size() - 1, p[j]});
        if (corrupt || p.size() == 0) exp_errs++;
        for (int j = 0; j < h.size(); j += 2) begin
            if (j + 1 < h.size()) send_beat({h[j], h[j+1]}, 4'b1111, j + 2 >= h.size());
            else send_beat({h[j], 16'hDEAD}, 4'b1100, 1'b1);
            if ($urandom_range(99) < gap_pct) begin
                repeat ($urandom_range(1, 3)) @(posedge aclk);
                #1;
            end
        end
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 3000) begin
            @(posedge aclk);
            t++;
        end
        if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
        repeat (4) @(posedge aclk);
        #1;
    endtask

    initial begin
        logic [15:0] p[$];
        channel_up = 1'b1;
        repeat (3) @(negedge aclk);
        check("rst_s_tready", s_axis_tready, 0);
        check("rst_m_tvalid", m_axis_tvalid, 0);
        check("rst_m_tdata", m_axis_tdata, 0);
        check("rst_m_tlast", m_axis_tlast, 0);
        check("rst_m_tuser", m_axis_tuser, 0);
        check("rst_crc_error", crc_error, 0);
`ifdef DNPCIE_AURORA_RX_ERRCNT_EN
        check("rst_err_count", err_count, 0);
`endif
        @(posedge aclk);
        #1 aresetn = 1'b1;
        @(negedge aclk);
        check("s_tready_first", s_axis_tready, 0);
        @(negedge aclk);
        check("s_tready_up", s_axis_tready, 1);
        @(posedge aclk);
        #1;

        p = '{16'h1234, 16'h5678, 16'h9ABC};
        send_payload(p, 0);
        drain();
        check("good_no_err", seen_errs, 0);
        p = '{16'hAAAA, 16'hBBBB};
        send_payload(p, 0);
        drain();
        p = '{16'h1234, 16'h5678, 16'h9ABC};
        send_payload(p, 1);
        drain();
        check("corrupt_err", seen_errs, 1);
`ifdef DNPCIE_AURORA_RX_ERRCNT_EN
        check("err_count_1", err_count, 1);
`endif
        p.delete();
        send_payload(p, 0);
        drain();
        check("runt_err", seen_errs, 2);

        exp_q.push_back({2'b00, 16'h1111});
        exp_q.push_back({2'b00, 16'h2222});
        exp_q.push_back({2'b00, 16'h3333});
        exp_q.push_back({2'b11, 16'h4444});
        exp_errs++;
        send_beat({16'h1111, 16'h2222}, 4'b1111, 1'b0);
        send_beat({16'h3333, 16'h4444}, 4'b1111, 1'b0);
        repeat (5) @(posedge aclk);
        #1 channel_up = 1'b0;
        @(negedge aclk);
        check("drop_s_tready", s_axis_tready, 0);
        repeat (3) @(posedge aclk);
        #1 channel_up = 1'b1;
        drain();
        check("drop_err", seen_errs, exp_errs);

        p.delete();
        for (int j = 0; j < 32; j++) p.push_back(16'h0100 + 16'(j));
        rmode = 2;
        fork
            send_payload(p, 0);
            begin
                repeat (10) @(posedge aclk);
                rmode = 3;
                repeat (5) @(negedge aclk);
                check("stall_s_tready", s_axis_tready, 0);
                repeat (15) @(posedge aclk);
                rmode = 2;
            end
        join
        drain();
        rmode = 0;

        rmode   = 1;
        gap_pct = 30;
        for (int f = 0; f < 40; f++) begin
            p.delete();
            repeat ($urandom_range(0, 9)) p.push_back(16'($urandom));
            send_payload(p, $urandom_range(0, 3) == 0);
        end
        drain();
        rmode = 0;
        drain();
        check("queue_empty", exp_q.size(), 0);
        check("err_pulses", seen_errs, exp_errs);
`ifdef DNPCIE_AURORA_RX_ERRCNT_EN
        check("err_count", err_count, 16'(exp_errs));
        force dut.err_cnt_q = 16'hFFFF;
        @(posedge aclk);
        #1 release dut.err_cnt_q;
        p.delete();
        send_payload(p, 0);
        drain();
        check("err_count_sat", err_count, 16'hFFFF);
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        check("global_timeout", 0, 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/dnpcie_aurora_rx_path_adapter.md
# dnpcie_aurora_rx_path_adapter

Receive-side counterpart of the DNPCIe Aurora transmit adapter. It takes the 32-bit big-endian Aurora user stream and splits each beat into 16-bit halfwords, first symbol first. It verifies and strips the trailing CRC-16 halfword, then delivers a 16-bit AXI4-Stream to the user logic with a per-frame error flag on the last beat. The adapter sits between the Aurora RX user interface and the 16-bit DNPCIe packet logic, and all of it is in-house RTL with no vendor width converter.

## Interface
- No parameters.
- Clock and reset: one clock; reset is asynchronous and active-low.
- `aclk` in 1: the single clock.
- `aresetn` in 1: asynchronous, active-low reset.
- `channel_up` in 1: Aurora channel status.
- `s_axis_tdata` in [0:31]: big-endian data. Bits [0:15] are the earlier halfword.
- `s_axis_tkeep` in [0:3]: byte enables. Legal values are 4'b1111, and 4'b1100 on a tlast beat only.
- `s_axis_tlast` in 1: end of frame. `s_axis_tvalid` in 1: input valid. `s_axis_tready` out 1: input ready.
- `m_axis_tdata` out [0:15]: payload halfword.
- `m_axis_tkeep` out [0:1]: always 2'b11.
- `m_axis_tlast` out 1: end of payload.
- `m_axis_tuser` out 1: frame error. Meaningful only when `m_axis_tlast` is 1.
- `m_axis_tvalid` out 1: output valid. `m_axis_tready` in 1: output ready.
- `crc_error` out 1: one-clock pulse for each bad or runt frame.
- `err_count` out 16: error counter. Present only with `DNPCIE_AURORA_RX_ERRCNT_EN`.

## Operation
- **Input register:** one beat deep.
  - `s_axis_tready` = `channel_up` && (register empty || its final halfword is being consumed this cycle).
- **Splitter:** a phase bit selects the halfword taken from the input register.
  - Phase 0 takes [0:15] / keep[0:1]. Phase 1 takes [16:31] / keep[2:3].
  - Phase 1 is skipped when keep[2:3] != 2'b11.
  - A halfword is marked last if the beat has tlast and it is the final halfword of that beat.
- **Bad keep:** a beat with keep[0:1] != 2'b11 is discarded whole and sets the frame's `bad` flag.
- **CRC:** CRC-16-CCITT.
  - Polynomial 0x1021, init 0xFFFF, MSB-first over tdata[0:15], no reflection, no final XOR.
  - It runs over every halfword of the frame, including the CRC halfword.
  - A good frame leaves a residue of 0x0000.
- **Stripper:** a one-halfword hold register (`hv`, `hd`).
  - Incoming halfword with `hv`=0: load `hd`, set `hv`.
  - Incoming halfword with `hv`=1: emit `hd` to the output register and load the new halfword into `hd`.
  - If the incoming halfword is last, `hd` is emitted with tlast=1 and tuser = `bad` || (residue != 0).
  - At end of frame, `hv`, `bad`, CRC and phase are cleared.
- **Runt frame:** a frame of one halfword, i.e. the first halfword is last.
  - Nothing is emitted.
  - `crc_error` pulses.
- **Error pulse:** `crc_error` pulses in the same cycle that any tlast beat with tuser=1 loads the output register.
- **Output register:** one halfword deep. A halfword advances only when the output register is empty or being drained that cycle, so backpressure stalls the splitter and then the input.
- **Channel drop:** when `channel_up` falls mid-frame:
  - `s_axis_tready` drops to 0.
  - The pending input beat is discarded.
  - If `hv`=1, `hd` is emitted with tlast=1 and tuser=1, and `crc_error` pulses. If `hv`=0, nothing is emitted.
  - All frame state is cleared.
  - A complete output beat already in the output register is unaffected.

## Timing
- **Reset values:** `s_axis_tready`=0 until the first clock after reset release with `channel_up`=1. `m_axis_tvalid`=0, `m_axis_tdata`=0, `m_axis_tlast`=0, `m_axis_tuser`=0, `crc_error`=0, `err_count`=0.
- **Reset mid-frame:** asserting reset mid-frame drops the frame silently.
- **Latency:** a halfword is visible on `m_axis` 2 clocks after its successor halfword enters the splitter. Beat N accepted at edge k gives halfword 0 at `m_axis` after edge k+2, with no backpressure.
- **Throughput:** one output halfword per clock. Input sustains one beat per 2 clocks.
- **Output holding:** `m_axis_*` is held stable while `tvalid`=1 and `tready`=0.
- **Back-to-back frames:** no idle cycle is required between frames.

## Configuration
- `DNPCIE_AURORA_RX_ERRCNT_EN` defined: `err_count` is a 16-bit saturating counter. It increments on each `crc_error` pulse and holds at 0xFFFF.
- `DNPCIE_AURORA_RX_ERRCNT_EN` undefined: the `err_count` port and its logic are absent. All other behaviour is identical.

## Test plan
- **Good frame:** payload 0x1234, 0x5678, 0x9ABC + correct CRC, sent as beats {1234,5678} and {9ABC,CRC} with keep 1111. Expect 3 output halfwords, tlast on 0x9ABC, tuser=0, no `crc_error`.
- **Odd length:** payload 0xAAAA, 0xBBBB + CRC, with a last beat {CRC,xxxx} keep 1100. Expect 2 halfwords, tlast on 0xBBBB, tuser=0.
- **Corrupted CRC:** good frame with one CRC bit flipped. Expect the same data, tuser=1, one `crc_error` pulse, `err_count`=1.
- **Runt and channel drop:**
  - Single halfword {CRC,xxxx} keep 1100 tlast → no output, `crc_error` pulse.
  - `channel_up` dropped after 2 payload beats → last held halfword emitted with tlast=1, tuser=1.
- **Backpressure:** `m_axis_tready` toggled 1010… and held low 20 clocks during a 32-halfword frame. Expect every halfword in order, none duplicated, and `s_axis_tready` deasserted while stalled.
- **Counter saturation:** force 0xFFFF errors, or preload in sim, then one more bad frame. Expect `err_count` to remain 0xFFFF.
